ibex_mult_pext_seq: RTL
=======================

IBEX_MULT_PEXT_SEQ -- requirements
Module: ibex_mult_pext_seq

Interface
REQ-001 SHALL provide parameter NUM_MUL, default 2, number of 17x17 signed partial-product multipliers instantiated; legal values 1, 2, 4.
REQ-002 SHALL provide ports clk_i input 1, clock; rst_i input 1, reset; clock and reset are a single clock with synchronous, active-high reset.
REQ-003 SHALL provide valid_i input 1 (request), ready_o output 1 (accept), kill_i input 1 (abort).
REQ-004 SHALL provide op_a_i input 32, op_b_i input 32, rd_val_i input 32 (accumulator source).
REQ-005 SHALL provide operator_i input mult_seq_op_e (MUL_LO, MUL_HI, MAC, MACSAT), width_i input mult_width_e (W8, W16, W32), signed_i input 1.
REQ-006 SHALL provide result_o output 32, sat_o output 1 (any lane saturated), valid_o output 1, ready_i input 1.

Function
REQ-007 Lanes: W8 = 4 lanes of 8 bits, W16 = 2 lanes of 16 bits, W32 = 1 lane; lane i occupies bits [i*w+w-1 : i*w].
REQ-008 Product count P: W8 = 4 (one 8x8 product per slot), W16 = 2, W32 = 4 (16x16 half products, shifted and summed to 64 bits).
REQ-009 Compute cycles C = ceil(P/NUM_MUL); NUM_MUL products computed per cycle, partial sums held in an internal 64-bit accumulator register.
REQ-010 Operands sign-extended to 17 bits when signed_i=1, zero-extended otherwise; W32 half products use upper half signedness only when signed_i=1.
REQ-011 MUL_LO: each lane = low w bits of the 2w-bit lane product.
REQ-012 MUL_HI: each lane = high w bits of the 2w-bit lane product.
REQ-013 MAC: each lane = rd_val_i lane + low w bits of product, modulo 2^w; sat_o = 0.
REQ-014 MACSAT: each lane = rd_val_i lane + full 2w-bit product, saturated to w-bit signed (signed_i=1) or unsigned (signed_i=0) range; sat_o = OR of per-lane saturation.
REQ-015 sat_o SHALL be 0 for all operators except MACSAT.
REQ-016 FSM states IDLE, CALC, DONE; IDLE -> CALC on valid_i&&ready_o; CALC -> DONE after C compute cycles; DONE -> IDLE on valid_o&&ready_i.
REQ-017 ready_o SHALL be 1 only in IDLE; no new request accepted in CALC or DONE.
REQ-018 Operands, operator, width, signedness and rd_val_i SHALL be captured on the accepting edge; later input changes have no effect.
REQ-019 valid_o SHALL rise exactly C+1 cycles after the accepting edge and stay 1 with result_o/sat_o stable until ready_i=1.
REQ-020 kill_i=1 in any state SHALL force IDLE on next edge, deassert valid_o, discard the operation; kill_i has priority over valid_i and ready_i.
REQ-021 kill_i in the same cycle as valid_i in IDLE SHALL prevent acceptance.
REQ-022 result_o and sat_o SHALL be 0 whenever valid_o=0.

Reset
REQ-023 rst_i=1 at a clock edge SHALL force IDLE, ready_o=1, valid_o=0, result_o=0, sat_o=0, accumulator and cycle counter cleared.
REQ-024 Reset during CALC or DONE SHALL discard the operation with no valid_o pulse afterwards.
REQ-025 rst_i SHALL take priority over kill_i and all handshake inputs.

Structure
REQ-026 mult_seq_op_e, mult_width_e and lane-count/product-count constants SHALL live in ibex_pkg_pext.
REQ-027 One sub-module ibex_mult_pext_pp (single 17x17 signed multiplier, combinational) SHALL be instantiated NUM_MUL times.
REQ-028 Product sequencing counter width SHALL be $clog2(4)+1 bits, independent of NUM_MUL.

Verification
REQ-029 W16 MUL_LO signed, a=0x0003FFFF, b=0x00040002 -> result_o=0x000CFFFE, sat_o=0, valid_o at C+1=2 cycles (NUM_MUL=2).
REQ-030 W32 MUL_HI signed, a=b=0x80000000, NUM_MUL=1 -> result_o=0x40000000, valid_o 5 cycles after accept; NUM_MUL=4 -> 2 cycles.
REQ-031 W8 MACSAT signed, rd=0x7F7F7F7F, a=b=0x01010101 -> result_o=0x7F7F7F7F, sat_o=1; same with MAC -> 0x80808080, sat_o=0.
REQ-032 Backpressure: W32 MUL_LO unsigned a=0xFFFFFFFF b=0x00000002, ready_i=0 for 3 cycles -> result_o=0xFFFFFFFE held stable, ready_o=0 throughout.
REQ-033 kill_i pulse in second CALC cycle -> no valid_o, ready_o=1 next cycle; following request completes normally.
REQ-034 rst_i asserted in DONE with ready_i=0 -> next cycle valid_o=0, result_o=0, ready_o=1.

Source files
------------

// File: rtl/ibex_pkg_pext.sv
// Shared types and per-width constants for the packed-SIMD sequential multiplier.
package ibex_pkg_pext;

    typedef enum logic [1:0] {
        MUL_LO = 2'd0,
        MUL_HI = 2'd1,
        MAC    = 2'd2,
        MACSAT = 2'd3
    } mult_seq_op_e;

    typedef enum logic [1:0] {
        W8  = 2'd0,
        W16 = 2'd1,
        W32 = 2'd2
    } mult_width_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mult_seq_state_e;

    localparam int unsigned MAX_PRODUCTS = 4;
    localparam int unsigned CNT_W        = $clog2(MAX_PRODUCTS) + 1;

    typedef struct packed {
        logic [31:0] val;
        logic        sat;
    } lane_res_t;

    function automatic int unsigned num_lanes(input mult_width_e w);
        int unsigned r;
        case (w)
            W8:      r = 4;
            W16:     r = 2;
            default: r = 1;
        endcase
        return r;
    endfunction

    function automatic int unsigned lane_bits(input mult_width_e w);
        int unsigned r;
        case (w)
            W8:      r = 8;
            W16:     r = 16;
            default: r = 32;
        endcase
        return r;
    endfunction

    // W32 is built from four 16x16 half products.
    function automatic int unsigned num_products(input mult_width_e w);
        int unsigned r;
        case (w)
            W16:     r = 2;
            default: r = 4;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ibex_mult_pext_pp.sv
// One 17x17 signed partial-product multiplier, purely combinational.
module ibex_mult_pext_pp (
    input  logic signed [16:0] op_a_i,
    input  logic signed [16:0] op_b_i,
    output logic signed [33:0] prod_o
);

    assign prod_o = op_a_i * op_b_i;

endmodule

// File: rtl/ibex_mult_pext_seq.sv
// Sequential packed-SIMD multiplier: NUM_MUL partial products per cycle into a
// 64-bit accumulator, then one finalisation cycle for MAC/saturation.
module ibex_mult_pext_seq
    import ibex_pkg_pext::*;
#(
    parameter int NUM_MUL = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic         kill_i,
    input  logic [31:0]  op_a_i,
    input  logic [31:0]  op_b_i,
    input  logic [31:0]  rd_val_i,
    input  mult_seq_op_e operator_i,
    input  mult_width_e  width_i,
    input  logic         signed_i,
    output logic [31:0]  result_o,
    output logic         sat_o,
    output logic         valid_o,
    input  logic         ready_i
);

    localparam int unsigned NM = NUM_MUL;

    mult_seq_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] num_cycles;
    logic             accept;

    logic [31:0]  op_a_p0, op_b_p0, rd_val_p0;
    mult_seq_op_e operator_p0;
    mult_width_e  width_p0;
    logic         signed_p0;

    logic [63:0]  acc_p1;
    logic [63:0]  acc_contrib;
    logic [31:0]  result_p2, result_d;
    logic         sat_p2, sat_d;

    logic signed [16:0] pp_a    [NUM_MUL];
    logic signed [16:0] pp_b    [NUM_MUL];
    logic signed [33:0] pp_prod [NUM_MUL];

    function automatic logic [CNT_W-1:0] cycles_for(input mult_width_e w);
        int unsigned c;
        c = (num_products(w) + NM - 1) / NM;
        return c[CNT_W-1:0];
    endfunction

    // W32 half products: slot bit1 selects the high half of a, bit0 of b;
    // only a high half carries the sign.
    function automatic logic signed [16:0] slot_operand(input logic [31:0] x, input mult_width_e w,
                                                        input logic sgn, input int unsigned slot,
                                                        input logic is_b);
        logic [31:0]        xs;
        logic               hi_half;
        logic signed [16:0] r;
        hi_half = is_b ? slot[0] : slot[1];
        case (w)
            W8: begin
                xs = x >> (8 * slot);
                r  = $signed({{9{sgn & xs[7]}}, xs[7:0]});
            end
            W16: begin
                xs = x >> (16 * slot);
                r  = $signed({sgn & xs[15], xs[15:0]});
            end
            default: begin
                xs = hi_half ? (x >> 16) : x;
                r  = $signed({sgn & hi_half & xs[15], xs[15:0]});
            end
        endcase
        return r;
    endfunction

    // Narrow lanes park their 2w-bit product in a private 2w-bit field.
    function automatic logic [63:0] place_product(input logic signed [33:0] p, input mult_width_e w,
                                                  input int unsigned slot);
        logic [63:0] r;
        case (w)
            W8:  r = {48'b0, p[15:0]} << (16 * slot);
            W16: r = {32'b0, p[31:0]} << (32 * slot);
            default: begin
                r = {{30{p[33]}}, p};
                if (slot == 3)      r = r << 32;
                else if (slot != 0) r = r << 16;
            end
        endcase
        return r;
    endfunction

    function automatic logic signed [65:0] ext66(input logic [63:0] v, input int unsigned bits,
                                                 input logic sgn);
        logic [65:0] m, r, top;
        m   = (66'd1 << bits) - 66'd1;
        r   = {2'b00, v} & m;
        top = {2'b00, v} >> (bits - 1);
        if (sgn && top[0]) r = r | ~m;
        return $signed(r);
    endfunction

    function automatic lane_res_t sat_lane(input logic signed [65:0] s, input int unsigned w,
                                           input logic sgn);
        logic signed [65:0] hi, lo;
        lane_res_t          r;
        if (sgn) begin
            hi = $signed((66'd1 << (w - 1)) - 66'd1);
            lo = -$signed(66'd1 << (w - 1));
        end else begin
            hi = $signed((66'd1 << w) - 66'd1);
            lo = '0;
        end
        r.val = s[31:0];
        r.sat = 1'b0;
        if (s > hi) begin
            r.val = hi[31:0];
            r.sat = 1'b1;
        end else if (s < lo) begin
            r.val = lo[31:0];
            r.sat = 1'b1;
        end
        return r;
    endfunction

    for (genvar m = 0; m < NUM_MUL; m++) begin : g_pp
        ibex_mult_pext_pp u_pp (
            .op_a_i (pp_a[m]),
            .op_b_i (pp_b[m]),
            .prod_o (pp_prod[m])
        );
    end

    assign num_cycles = cycles_for(width_p0);
    assign accept     = valid_i && (state_q == IDLE) && !kill_i;

    always_comb begin
        for (int m = 0; m < NUM_MUL; m++) begin
            pp_a[m] = slot_operand(op_a_p0, width_p0, signed_p0, 32'(cnt_q) * NM + m, 1'b0);
            pp_b[m] = slot_operand(op_b_p0, width_p0, signed_p0, 32'(cnt_q) * NM + m, 1'b1);
        end
    end

    always_comb begin
        acc_contrib = '0;
        for (int m = 0; m < NUM_MUL; m++) begin
            if (32'(cnt_q) * NM + m < num_products(width_p0)) begin
                acc_contrib = acc_contrib + place_product(pp_prod[m], width_p0, 32'(cnt_q) * NM + m);
            end
        end
    end

    always_comb begin : finalise
        int unsigned        n, w;
        logic [63:0]        mask, pf, rf, lv, res64;
        logic signed [65:0] sum;
        lane_res_t          ls;
        n     = num_lanes(width_p0);
        w     = lane_bits(width_p0);
        mask  = (64'd1 << w) - 64'd1;
        pf    = '0;
        rf    = '0;
        lv    = '0;
        res64 = '0;
        sum   = '0;
        ls    = '0;
        sat_d = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            if (k < n) begin
                pf = acc_p1 >> (k * 2 * w);
                rf = {32'b0, rd_val_p0} >> (k * w);
                case (operator_p0)
                    MUL_LO: lv = pf & mask;
                    MUL_HI: lv = (pf >> w) & mask;
                    MAC:    lv = (rf + pf) & mask;
                    default: begin
                        sum   = ext66(rf & mask, w, signed_p0) + ext66(pf, 2 * w, signed_p0);
                        ls    = sat_lane(sum, w, signed_p0);
                        lv    = {32'b0, ls.val} & mask;
                        sat_d = sat_d | ls.sat;
                    end
                endcase
                res64 = res64 | (lv << (k * w));
            end
        end
        result_d = res64[31:0];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = CALC;
            CALC:    if (cnt_q == num_cycles) state_d = DONE;
            DONE:    if (ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (kill_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Stage p0: request capture
    always_ff @(posedge clk_i) begin
        if (accept) begin
            op_a_p0     <= op_a_i;
            op_b_p0     <= op_b_i;
            rd_val_p0   <= rd_val_i;
            operator_p0 <= operator_i;
            width_p0    <= width_i;
            signed_p0   <= signed_i;
        end
    end

    // Stage p1/p2: accumulate C cycles, then register the finalised lanes
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            acc_p1    <= '0;
            result_p2 <= '0;
            sat_p2    <= 1'b0;
        end else if (accept) begin
            cnt_q  <= '0;
            acc_p1 <= '0;
        end else if (state_q == CALC && !kill_i) begin
            if (cnt_q != num_cycles) begin
                acc_p1 <= acc_p1 + acc_contrib;
                cnt_q  <= cnt_q + 1'b1;
            end else begin
                result_p2 <= result_d;
                sat_p2    <= sat_d;
            end
        end
    end

    assign ready_o  = (state_q == IDLE);
    assign valid_o  = (state_q == DONE);
    assign result_o = valid_o ? result_p2 : '0;
    assign sat_o    = valid_o & sat_p2;

endmodule
